// File: rtl/perceptron_train.sv
// perceptron_train: single-neuron perceptron with serial accumulation and
// on-chip perceptron-rule training.
//   - One input is accumulated per cycle (ACC).
//   - The class decision is taken in DECIDE.
//   - On a training misclassification, one weight per cycle is stepped in UPDATE.
// Optional feature macro: PERCEPTRON_BIAS_EN adds a trainable bias register.
//   - The accumulator starts at the bias value instead of zero.
//   - The bias takes the same +1/-1 step in the first UPDATE cycle.
module perceptron_train #(
    parameter int N_IN    = 25,
    parameter int W_WIDTH = 8,
    parameter int ERR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in,
    input  logic              label,
    input  logic              train,
    input  logic              en,
    output logic              ready,
    output logic [1:0]        out,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int ACC_W = W_WIDTH + $clog2(N_IN + 1) + 1;
    localparam int IDX_W = $clog2(N_IN);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1'b1);
    localparam logic [ERR_W-1:0]   ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0]   ERR_ONE  = ERR_W'(1'b1);
    localparam logic [W_WIDTH-1:0] W_MAX    = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic [W_WIDTH-1:0] W_MIN    = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic [W_WIDTH-1:0] W_ONE    = W_WIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_DECIDE = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [ACC_W-1:0]    acc_r;
    logic [N_IN-1:0]     in_q_r;
    logic                label_q_r;
    logic                train_q_r;
    logic                ready_r;
    logic [1:0]          out_r;
    logic [ERR_W-1:0]    err_cnt_r;
    logic [W_WIDTH-1:0]  weight_r [N_IN];

    logic [W_WIDTH-1:0]  w_sel_s;
    logic [ACC_W-1:0]    w_ext_s;
    logic [ACC_W-1:0]    acc_next_s;
    logic [ACC_W-1:0]    acc_init_s;
    logic                class_s;
    logic                err_s;

`ifdef PERCEPTRON_BIAS_EN
    logic [W_WIDTH-1:0]  bias_r;
`endif

    // Saturating +1 (up=1) or -1 (up=0) step on a signed weight.
    function automatic logic [W_WIDTH-1:0] sat_step(input logic [W_WIDTH-1:0] w,
                                                    input logic up);
        logic [W_WIDTH-1:0] r;
        if (up) begin
            r = (w == W_MAX) ? w : (w + W_ONE);
        end else begin
            r = (w == W_MIN) ? w : (w - W_ONE);
        end
        return r;
    endfunction

    // Datapath: selected weight, next accumulator value and class/error decision.
    always_comb begin
        w_sel_s    = weight_r[idx_r];
        w_ext_s    = {{(ACC_W-W_WIDTH){w_sel_s[W_WIDTH-1]}}, w_sel_s};
        if (in_q_r[idx_r]) begin
            acc_next_s = acc_r + w_ext_s;
        end else begin
            acc_next_s = acc_r;
        end
`ifdef PERCEPTRON_BIAS_EN
        acc_init_s = {{(ACC_W-W_WIDTH){bias_r[W_WIDTH-1]}}, bias_r};
`else
        acc_init_s = {ACC_W{1'b0}};
`endif
        // Strictly positive: sign bit clear and not zero.
        class_s    = ~acc_r[ACC_W-1] & (|acc_r);
        err_s      = train_q_r & (class_s != label_q_r);
    end

    // Control FSM with registered handshake, result and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= {IDX_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            in_q_r    <= {N_IN{1'b0}};
            label_q_r <= 1'b0;
            train_q_r <= 1'b0;
            ready_r   <= 1'b1;
            out_r     <= 2'b00;
            err_cnt_r <= {ERR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        in_q_r    <= in;
                        label_q_r <= label;
                        train_q_r <= train;
                        acc_r     <= acc_init_s;
                        idx_r     <= {IDX_W{1'b0}};
                        ready_r   <= 1'b0;
                        state_r   <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_next_s;
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DECIDE;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_DECIDE: begin
                    out_r <= {err_s, class_s};
                    if (err_s) begin
                        if (err_cnt_r != ERR_MAX) begin
                            err_cnt_r <= err_cnt_r + ERR_ONE;
                        end
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= ST_UPDATE;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    if (idx_r == LAST_IDX) begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Weight bank: one saturating step per UPDATE cycle on active inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                weight_r[i] <= {W_WIDTH{1'b0}};
            end
        end else if ((state_r == ST_UPDATE) && in_q_r[idx_r]) begin
            weight_r[idx_r] <= sat_step(weight_r[idx_r], label_q_r);
        end
    end

`ifdef PERCEPTRON_BIAS_EN
    // Bias register: implicit always-1 input, stepped in the first UPDATE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_r <= {W_WIDTH{1'b0}};
        end else if ((state_r == ST_UPDATE) && (idx_r == {IDX_W{1'b0}})) begin
            bias_r <= sat_step(bias_r, label_q_r);
        end
    end
`endif

    assign ready   = ready_r;
    assign out     = out_r;
    assign err_cnt = err_cnt_r;

endmodule
